fetch_prefetch_buffer: RTL

FETCH_PREFETCH_BUFFER -- requirements
Module: fetch_prefetch_buffer

---
 rtl/fetch_prefetch_buffer_if.sv | 29 ++
 rtl/fetch_prefetch_buffer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_buffer_if.sv
// Handshake and bus signals of the instruction prefetch buffer.
// master: the prefetch buffer itself; slave: control unit, consumer and bus.
interface fetch_prefetch_buffer_if;
   logic        req_i;
   logic        branch_i;
   logic [31:0] branch_addr_i;
   logic        ready_i;
   logic        valid_o;
   logic [31:0] rdata_o;
   logic [31:0] addr_o;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;
   logic        busy_o;

   modport master (
      input  req_i, branch_i, branch_addr_i, ready_i,
      input  instr_gnt_i, instr_rvalid_i, instr_rdata_i,
      output valid_o, rdata_o, addr_o, instr_req_o, instr_addr_o, busy_o
   );

   modport slave (
      output req_i, branch_i, branch_addr_i, ready_i,
      output instr_gnt_i, instr_rvalid_i, instr_rdata_i,
      input  valid_o, rdata_o, addr_o, instr_req_o, instr_addr_o, busy_o
   );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential word fetches on a req/gnt/rvalid bus,
// queues responses in a FIFO for IF/ID and flushes/redirects on branch.
module fetch_prefetch_buffer #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] BOOT_ADDR       = 32'h0000_0080
) (
   input logic                     clk,
   input logic                     rst,
   fetch_prefetch_buffer_if.master bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CW-1:0] MAX_O   = CW'(MAX_OUTSTANDING);
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);
   localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
   localparam logic [QW-1:0] AQ_LAST = QW'(MAX_OUTSTANDING - 1);

   typedef enum logic {IDLE, WAIT_GNT} state_t;

   state_t        state;
   logic [31:0]   fetch_addr;
   logic [31:0]   held_addr;
   logic          held_stale;
   logic [CW-1:0] out_cnt;
   logic [CW-1:0] discard_cnt;
   logic [CW-1:0] fifo_cnt;
   logic [31:0]   fifo_data [DEPTH];
   logic [31:0]   fifo_addr [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [31:0]   aq [MAX_OUTSTANDING];
   logic [QW-1:0] aq_rd;
   logic [QW-1:0] aq_wr;

   logic          credit;
   logic          gnt_fire;
   logic          stale_gnt;
   logic          push;
   logic          pop;
   logic [CW:0]   inflight;
   logic [CW-1:0] out_next;
   logic          unused_addr_lsb;

   always_comb begin
      inflight  = {1'b0, out_cnt} + {1'b0, fifo_cnt};
      credit    = (out_cnt < MAX_O) && (inflight < DEPTH_W);
      // A started request must stay on the bus until granted, even across a branch.
      if (state == WAIT_GNT) begin
         bus.instr_req_o  = !rst;
         bus.instr_addr_o = held_addr;
      end else begin
         bus.instr_req_o  = !rst && bus.req_i && !bus.branch_i && credit;
         bus.instr_addr_o = fetch_addr;
      end
      gnt_fire  = bus.instr_req_o && bus.instr_gnt_i;
      stale_gnt = gnt_fire && (state == WAIT_GNT) && held_stale;
      push      = bus.instr_rvalid_i && (discard_cnt == '0) && !bus.branch_i;
      pop       = (fifo_cnt != '0) && bus.ready_i && !bus.branch_i;
      out_next  = out_cnt + CW'(gnt_fire) - CW'(bus.instr_rvalid_i);

      bus.valid_o     = (fifo_cnt != '0);
      bus.rdata_o     = fifo_data[rd_ptr];
      bus.addr_o      = fifo_addr[rd_ptr];
      bus.busy_o      = (out_cnt != '0) || (fifo_cnt != '0);
      unused_addr_lsb = ^bus.branch_addr_i[1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         fetch_addr  <= BOOT_ADDR;
         held_addr   <= BOOT_ADDR;
         held_stale  <= 1'b0;
         out_cnt     <= '0;
         discard_cnt <= '0;
         fifo_cnt    <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         aq_rd       <= '0;
         aq_wr       <= '0;
      end else begin
         out_cnt <= out_next;

         if (bus.branch_i) begin
            fifo_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (push) begin
               fifo_data[wr_ptr] <= bus.instr_rdata_i;
               fifo_addr[wr_ptr] <= aq[aq_rd];
               wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
         end

         // Every grant is tracked, discarded or not, so addresses stay aligned with responses.
         if (gnt_fire) begin
            aq[aq_wr] <= bus.instr_addr_o;
            aq_wr     <= (aq_wr == AQ_LAST) ? '0 : aq_wr + 1'b1;
         end
         if (bus.instr_rvalid_i) aq_rd <= (aq_rd == AQ_LAST) ? '0 : aq_rd + 1'b1;

         if (bus.branch_i)
            discard_cnt <= out_next;
         else
            discard_cnt <= discard_cnt + CW'(stale_gnt)
                           - CW'(bus.instr_rvalid_i && (discard_cnt != '0));

         if (bus.branch_i)
            fetch_addr <= {bus.branch_addr_i[31:2], 2'b00};
         else if (gnt_fire && !stale_gnt)
            fetch_addr <= bus.instr_addr_o + 32'd4;

         case (state)
            IDLE: begin
               if (bus.instr_req_o && !bus.instr_gnt_i) begin
                  state      <= WAIT_GNT;
                  held_addr  <= fetch_addr;
                  held_stale <= 1'b0;
               end
            end
            WAIT_GNT: begin
               if (bus.instr_gnt_i) begin
                  state      <= IDLE;
                  held_stale <= 1'b0;
               end else if (bus.branch_i) begin
                  held_stale <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) assert (fifo_cnt != FULL);
   end
endmodule
